// File: rtl/exp3_unidade_controle.sv
// exp3_unidade_controle: control unit for the exp3 memory-check datapath.
// Sequences one pass over the 16-entry ROM. For each player move it latches
// the switches, checks the comparator and advances the address. The pass ends
// in a success, error or timeout state.
module exp3_unidade_controle #(
    parameter int unsigned TIMEOUT_CICLOS = 0,
    parameter int unsigned TW             = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // State codes double as the debug code shown on db_estado.
    typedef enum logic [3:0] {
        inicial     = 4'h0,
        preparacao  = 4'h1,
        espera      = 4'h2,
        registra    = 4'h4,
        comparacao  = 4'h5,
        proximo     = 4'h6,
        fim_acertou = 4'hA,
        fim_errou   = 4'hE,
        fim_timeout = 4'hF
    } estado_t;

    localparam bit            TEMPORIZA = (TIMEOUT_CICLOS > 0);
    localparam logic [TW-1:0] LIMITE    = TEMPORIZA ? TW'(TIMEOUT_CICLOS - 1) : '0;

    estado_t       estado;
    estado_t       prox;
    logic          jogada_d;
    logic [TW-1:0] cont_espera;
    logic          pulso;
    logic          expirou;

    // Rising edge of the move button. A button already held when espera is
    // entered gives no pulse, because jogada_d is already high.
    assign pulso   = jogada & ~jogada_d;
    assign expirou = TEMPORIZA && (cont_espera == LIMITE);

    // Transition rules. Unknown codes fall back to inicial.
    function automatic estado_t proximo_estado(
        input estado_t atual,
        input logic    pulso_i,
        input logic    expirou_i,
        input logic    iniciar_i,
        input logic    igual_i,
        input logic    fim_i
    );
        estado_t nxt;
        nxt = inicial;
        case (atual)
            inicial:     nxt = iniciar_i ? preparacao : inicial;
            preparacao:  nxt = espera;
            // A move in the same cycle as the timeout is accepted.
            espera:      nxt = pulso_i   ? registra    :
                               expirou_i ? fim_timeout : espera;
            registra:    nxt = comparacao;
            // A mismatch is checked before the end-of-ROM flag, so a wrong
            // entry at address 15 still ends in fim_errou.
            comparacao:  nxt = !igual_i ? fim_errou   :
                               fim_i    ? fim_acertou : proximo;
            proximo:     nxt = espera;
            fim_acertou,
            fim_errou,
            fim_timeout: nxt = iniciar_i ? preparacao : atual;
            default:     nxt = inicial;
        endcase
        return nxt;
    endfunction

    // Output pattern of each state, in the order
    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}.
    function automatic logic [7:0] saidas(input estado_t e);
        logic [7:0] s;
        s = 8'b0000_0000;
        case (e)
            preparacao:  s = 8'b1010_0000;
            registra:    s = 8'b0001_0000;
            proximo:     s = 8'b0100_0000;
            fim_acertou: s = 8'b0000_1100;
            fim_errou:   s = 8'b0000_1010;
            fim_timeout: s = 8'b0000_1011;
            default:     s = 8'b0000_0000;
        endcase
        return s;
    endfunction

    assign prox = proximo_estado(estado, pulso, expirou, iniciar,
                                 chavesIgualMemoria, fimC);

    // State register, edge-detect flop, espera timer and registered outputs.
    // NOTE: the outputs are registered from the next state, so each one changes
    // on the same edge as the state register and always matches its state.
    always_ff @(posedge clock) begin
        // NOTE: this block uses only non-blocking assignments. Every register
        // then updates from values taken before the edge, with no
        // order-dependent races between the assignments.
        if (reset) begin
            estado      <= inicial;
            jogada_d    <= 1'b0;
            cont_espera <= '0;
            {zeraC, contaC, zeraR, registraR,
             pronto, acertou, errou, timeout} <= 8'b0000_0000;
        end else begin
            estado      <= prox;
            jogada_d    <= jogada;
            cont_espera <= (estado == espera) ? cont_espera + TW'(1) : '0;
            {zeraC, contaC, zeraR, registraR,
             pronto, acertou, errou, timeout} <= saidas(prox);
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Testbench for exp3_unidade_controle. A small datapath model (address
// counter, switch register, synchronous ROM) closes the loop around the DUT.
// The expected result of each pass comes from walking the planned switch
// values against the ROM, and goes into a scoreboard queue. A monitor pops
// that queue when pronto rises.
module tb_exp3_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b1;
    logic       jogada = 1'b1;
    logic       chavesIgualMemoria;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [7:0] outs;

    exp3_unidade_controle #(.TIMEOUT_CICLOS(20), .TW(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimC               (fimC),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .timeout            (timeout),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    assign outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};

    // Datapath model
    logic [3:0] rom [16];
    logic [3:0] plan_sw [16];
    logic [3:0] chaves = 4'h0;
    logic [3:0] addr   = 4'h0;
    logic [3:0] sw_reg = 4'h0;
    logic [3:0] rom_q  = 4'h0;

    always @(posedge clock) begin
        if (zeraC)       addr <= 4'h0;
        else if (contaC) addr <= addr + 4'h1;
        if (zeraR)          sw_reg <= 4'h0;
        else if (registraR) sw_reg <= chaves;
        rom_q <= rom[addr];
    end

    assign chavesIgualMemoria = (sw_reg == rom_q);
    assign fimC               = (addr == 4'hF);

    // Scoreboard
    typedef struct {
        int estado;
        int acertou;
        int errou;
        int tmo;
        int fim;
        int n_reg;
        int n_conta;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_reg = 0;
    int   n_conta = 0;
    int   fim_seen = 0;
    logic pronto_q = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: walk the planned moves through the ROM in order. The first
    // wrong entry ends the pass with an error. The 16th correct entry ends it
    // with success. Running out of moves ends it by timeout.
    function automatic exp_t model(input int presses);
        exp_t e;
        e.estado = 'hF; e.acertou = 0; e.errou = 1; e.tmo = 1;
        e.n_reg = 0; e.n_conta = 0;
        for (int i = 0; i < presses; i++) begin
            e.n_reg++;
            if (plan_sw[i] != rom[i]) begin
                e.estado = 'hE; e.tmo = 0;
                break;
            end
            if (i == 15) begin
                e.estado = 'hA; e.acertou = 1; e.errou = 0; e.tmo = 0;
                break;
            end
            e.n_conta++;
        end
        e.fim = (e.n_conta == 15) ? 1 : 0;
        return e;
    endfunction

    // Monitor: counts datapath strobes per pass and scores each pass end.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (zeraC) begin
                n_reg = 0; n_conta = 0; fim_seen = 0;
            end else begin
                if (registraR) n_reg++;
                if (contaC)    n_conta++;
                if (fimC)      fim_seen = 1;
            end
            if (pronto && !pronto_q) begin
                check("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("end_estado",  int'(db_estado), e.estado);
                    check("end_acertou", int'(acertou), e.acertou);
                    check("end_errou",   int'(errou), e.errou);
                    check("end_timeout", int'(timeout), e.tmo);
                    check("end_n_registraR", n_reg, e.n_reg);
                    check("end_n_contaC", n_conta, e.n_conta);
                    check("end_fimC_seen", fim_seen, e.fim);
                end
            end
            pronto_q = pronto;
        end
    end

    // Driver helpers
    task automatic wait_state(input int s, input int budget, input string name);
        for (int k = 0; k < budget && int'(db_estado) != s; k++) @(negedge clock);
        check(name, int'(db_estado), s);
    endtask

    task automatic wait_pronto(input int budget);
        for (int k = 0; k < budget && !pronto; k++) @(negedge clock);
        check("pass_end_seen", int'(pronto), 1);
    endtask

    task automatic start_pass();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        wait_state('h2, 6, "enter_espera");
    endtask

    task automatic run_pass(input int n_ok, input bit do_tmo, input bit do_start,
                            input bit glitch, input int hold);
        int presses;
        int h;
        int l;
        for (int i = 0; i < 16; i++)
            plan_sw[i] = (i < n_ok) ? rom[i] : rom[i] ^ 4'($urandom_range(1, 15));
        presses = do_tmo ? n_ok : ((n_ok >= 16) ? 16 : n_ok + 1);
        sb.push_back(model(presses));
        if (do_start) start_pass();
        for (int i = 0; i < presses; i++) begin
            chaves = plan_sw[i];
            if (glitch && i == 0 && n_ok >= 1 && presses >= 2) begin
                jogada = 1'b1;
                @(negedge clock);
                jogada = 1'b0;
                repeat (2) @(negedge clock);
                check("glitch_in_proximo", int'(db_estado), 'h6);
                jogada = 1'b1;
                @(negedge clock);
                jogada = 1'b0;
                repeat (4) @(negedge clock);
                check("glitch_ignored", int'(db_estado), 'h2);
            end else begin
                h = (hold > 0) ? hold : int'($urandom_range(1, 5));
                l = ((h >= 3) ? 1 : 4 - h) + int'($urandom_range(0, 3));
                jogada = 1'b1;
                repeat (h) @(negedge clock);
                jogada = 1'b0;
                repeat (l) @(negedge clock);
            end
        end
        wait_pronto(60);
    endtask

    // Stimulus
    initial begin
        int n;
        int n_ok;
        bit tmo;
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);

        // Reset held with iniciar and jogada high
        @(negedge clock);
        check("reset_c1_estado", int'(db_estado), 0);
        check("reset_c1_outs", int'(outs), 0);
        @(negedge clock);
        check("reset_c2_estado", int'(db_estado), 0);
        check("reset_c2_outs", int'(outs), 0);
        reset = 1'b0;
        @(negedge clock);
        check("prep_estado", int'(db_estado), 'h1);
        check("prep_zera", int'({zeraC, zeraR}), 3);
        iniciar = 1'b0;
        @(negedge clock);
        check("espera_estado", int'(db_estado), 'h2);
        check("espera_zera_off", int'({zeraC, zeraR}), 0);
        repeat (6) @(negedge clock);
        check("held_no_registra", int'(db_estado), 'h2);
        jogada = 1'b0;
        @(negedge clock);
        run_pass(16, 1'b0, 1'b0, 1'b0, 5);

        // Timeout exactly 20 cycles after entering espera
        sb.push_back(model(0));
        start_pass();
        n = 0;
        while (int'(db_estado) != 'hF && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("timeout_latency", n, 20);

        // A move on the 20th espera cycle wins over the timeout
        plan_sw[0] = rom[0] ^ 4'h5;
        sb.push_back(model(1));
        start_pass();
        repeat (19) @(negedge clock);
        chaves = plan_sw[0];
        jogada = 1'b1;
        @(negedge clock);
        check("pulso_beats_timeout", int'(db_estado), 'h4);
        jogada = 1'b0;
        wait_pronto(20);

        // Mismatch at address 3, with a glitch press in proximo
        run_pass(3, 1'b0, 1'b1, 1'b1, 0);

        // Restart straight from fim_errou
        iniciar = 1'b1;
        @(negedge clock);
        check("restart_estado", int'(db_estado), 'h1);
        check("restart_zeraC", int'(zeraC), 1);
        iniciar = 1'b0;
        @(negedge clock);
        check("restart_espera", int'(db_estado), 'h2);
        run_pass(16, 1'b0, 1'b0, 1'b0, 0);

        // Reset while in comparacao
        start_pass();
        chaves = rom[0];
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        @(negedge clock);
        check("in_comparacao", int'(db_estado), 'h5);
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_estado", int'(db_estado), 0);
        check("reset_mid_outs", int'(outs), 0);
        reset = 1'b0;
        @(negedge clock);
        check("stay_inicial", int'(db_estado), 0);

        // Random passes
        for (int p = 0; p < 10; p++) begin
            n_ok = int'($urandom_range(0, 16));
            tmo  = (n_ok < 16) && ($urandom_range(0, 2) == 0);
            run_pass(n_ok, tmo, 1'b1, 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/exp3_unidade_controle.md
Name: exp3_unidade_controle

Overview:
Control unit for the exp3 memory-check datapath. It sequences one full pass over the 16-entry ROM: clears the address counter and switch register, waits for each player move, latches the switches, checks the comparator result and advances the address. It ends in a success, error or timeout state. It sits directly beside exp3_fluxo_dados:
- It drives zeraC, contaC, zeraR and registraR.
- It consumes chavesIgualMemoria and fimC.

Parameters:
TIMEOUT_CICLOS, 0, cycles allowed in espera before timeout. 0 disables the timeout.
TW, 16, width of the internal timeout counter. Must satisfy 2^TW > TIMEOUT_CICLOS.

Ports:
clock  input  1  system clock; everything is rising-edge.
reset  input  1  synchronous, active-high reset.
iniciar  input  1  start/restart request, level-sampled.
jogada  input  1  player move button, may be held many cycles.
chavesIgualMemoria  input  1  from datapath: registered switches equal ROM data.
fimC  input  1  from datapath: address counter at 15.
zeraC  output  1  synchronous clear of the address counter.
contaC  output  1  address counter count enable.
zeraR  output  1  synchronous clear of the switch register.
registraR  output  1  switch register load enable.
pronto  output  1  pass finished (any end state).
acertou  output  1  pass finished with all 16 entries matching.
errou  output  1  pass finished by mismatch or timeout.
timeout  output  1  pass finished by timeout.
db_estado  output  4  current state code, for debug.

Behaviour:
- Moore FSM; all outputs decode from the state register only.
- Synchronous reset:
  - state=inicial; edge-detect flop=0; timeout counter=0.
  - All control and status outputs 0; db_estado=4'h0.
- Edge detector: jogada_d <= jogada every cycle; pulso = jogada & ~jogada_d.
  - Acted on only in espera. Edges in other states are discarded, not queued.
  - A button held across the espera entry produces no pulse.
- State codes (db_estado), outputs and transitions:
  - inicial (0x0): no outputs. iniciar=1 -> preparacao.
  - preparacao (0x1): zeraC=1, zeraR=1. Lasts 1 cycle, then -> espera.
  - espera (0x2): no outputs; the timeout counter increments each cycle.
    - pulso -> registra, even if the timeout is reached in the same cycle; pulso wins.
    - Otherwise, TIMEOUT_CICLOS>0 and counter==TIMEOUT_CICLOS-1 -> fim_timeout.
    - Otherwise stay.
    - The counter clears on every cycle the state is not espera.
  - registra (0x4): registraR=1. Lasts 1 cycle, then -> comparacao.
  - comparacao (0x5): no outputs. One cycle after registra, so both the register and the synchronous ROM output are valid.
    - chavesIgualMemoria=0 -> fim_errou.
    - Else fimC=1 -> fim_acertou.
    - Else -> proximo.
  - proximo (0x6): contaC=1. Lasts 1 cycle, then -> espera.
  - fim_acertou (0xA): pronto=1, acertou=1.
  - fim_errou (0xE): pronto=1, errou=1.
  - fim_timeout (0xF): pronto=1, errou=1, timeout=1.
  - All three end states hold until iniciar=1 -> preparacao (restart with no return to inicial).
- Any unused code -> inicial on the next clock, with outputs 0.
- Mismatch at address 15 goes to fim_errou: the mismatch check takes priority over fimC.
- Reset asserted mid-pass: the next state is inicial regardless of inputs; the datapath is re-cleared only by the next preparacao.
- Minimum time per move, from pulso detected to back in espera: 3 cycles (registra, comparacao, proximo).
- Full correct pass: 16 pulsos and 15 contaC cycles; the address never wraps.

Test Plan:
- Reset for 2 cycles with iniciar=1 and jogada=1 -> during reset all outputs 0 and db_estado=0. After release: preparacao (zeraC=zeraR=1 for exactly one cycle), then espera.
- Start, then 16 jogada presses (each held 5 cycles) with switches matching ROM -> registraR pulses 16 times, contaC 15 times. Ends in db_estado=0xA with pronto=1, acertou=1, errou=0.
- Start, match at addresses 0-2, wrong switches at address 3 -> db_estado=0xE, errou=1, contaC pulsed 3 times, fimC never seen.
- TIMEOUT_CICLOS=20: start, no jogada -> fim_timeout exactly 20 cycles after entering espera, with timeout=errou=pronto=1. A pulso on cycle 20 instead goes to registra.
- jogada held high through preparacao into espera -> no registraR until jogada falls and rises again. A 1-cycle jogada pulse during registra or proximo is ignored.
- From fim_errou assert iniciar=1 -> preparacao on the next cycle (zeraC=1) and the pass restarts at address 0. Reset asserted while in comparacao -> inicial on the next edge.
